// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the 64-bit bitwise ALU and the accumulator sequencer that
// feeds it.
//   alu_mode_t  : ALU operation select (XOR, ~a&b, ~a, zero)
//   seq_state_t : sequencer FSM states
//   DATA_W      : datapath width shared by the ALU and the sequencer
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    ALU_XOR  = 2'd0,
    ALU_ANDN = 2'd1,
    ALU_NOT  = 2'd2,
    ALU_ZERO = 2'd3
  } alu_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage : alu_pkg

// File: rtl/alu_acc_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_acc_sequencer_if
// Bundles the sequencer's streaming and ALU-facing signals.
//   in_valid/in_ready/in_data/in_mode : incoming (word, op) stream
//   out_valid/out_ready/out_data      : final accumulator result stream
//   alu_a/alu_b/alu_mode/alu_y        : link to the external combinational ALU
// Modports:
//   slave  : the sequencer's view (consumes input stream, produces result)
//   master : the surrounding environment's view
// ---------------------------------------------------------------------------
interface alu_acc_sequencer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  alu_mode_t        in_mode;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  alu_mode_t        alu_mode;
  logic [WIDTH-1:0] alu_y;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready, alu_y,
    output in_ready, out_valid, out_data, alu_a, alu_b, alu_mode
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready, alu_y,
    input  in_ready, out_valid, out_data, alu_a, alu_b, alu_mode
  );

endinterface : alu_acc_sequencer_if

// File: rtl/alu_acc_sequencer.sv
// ---------------------------------------------------------------------------
// alu_acc_sequencer
// Holds a WIDTH-bit accumulator, seeds it on start, then folds a burst of
// len (word, op) pairs through the external ALU (a=acc, b=word, mode=op),
// writing each result back into acc. The final acc is offered on the
// output stream; the block returns to IDLE after the result handshake.
// Ports:
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   start          : begin a burst (sampled only in IDLE)
//   init_val, len  : accumulator seed and burst length, captured with start
//   bus (slave)    : input stream, output stream and ALU link
//   busy           : high whenever the FSM is not in IDLE
//   remaining      : words still to be accepted in the current burst
// ---------------------------------------------------------------------------
module alu_acc_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int LEN_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    init_val,
  input  logic [LEN_W-1:0]    len,
  alu_acc_sequencer_if.slave  bus,
  output logic                busy,
  output logic [LEN_W-1:0]    remaining
);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  // Next-state, accumulator and burst-counter logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = init_val;
          rem_d = len;
          // An empty burst goes straight to presenting the seed.
          if (len != {LEN_W{1'b0}}) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // in_ready is unconditionally high in RUN, so in_valid alone is an accept.
        if (bus.in_valid) begin
          acc_d = bus.alu_y;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        // start is deliberately not looked at here; it must wait for IDLE.
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, accumulator and burst-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= {WIDTH{1'b0}};
      rem_q   <= {LEN_W{1'b0}};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  // Output decode: handshakes from state flops, datapath straight from acc.
  always_comb begin
    bus.in_ready  = (state_q == RUN);
    bus.out_valid = (state_q == DONE);
    bus.out_data  = acc_q;
    bus.alu_a     = acc_q;
    bus.alu_b     = bus.in_data;
    bus.alu_mode  = bus.in_mode;
    busy          = (state_q != IDLE);
    remaining     = rem_q;
  end

endmodule : alu_acc_sequencer

// File: tb/tb_alu_acc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_acc_sequencer
// Directed and randomized bench for alu_acc_sequencer. A combinational ALU
// sits alongside the DUT on the alu_* link. Expected accumulator values come
// from a word-level reference that folds each burst with plain operators.
// ---------------------------------------------------------------------------
module tb_alu_acc_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] init_val = 64'd0;
  logic [7:0]  len = 8'd0;
  logic        busy;
  logic [7:0]  remaining;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] w_data [16];
  logic [1:0]  w_mode [16];
  int          w_gap  [16];

  alu_acc_sequencer_if #(.WIDTH(64)) bus ();

  alu_acc_sequencer #(.WIDTH(64), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .init_val  (init_val),
    .len       (len),
    .bus       (bus.slave),
    .busy      (busy),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  // The external bitwise ALU the sequencer drives.
  assign bus.alu_y = (bus.alu_mode == ALU_XOR)  ? (bus.alu_a ^ bus.alu_b) :
                     (bus.alu_mode == ALU_ANDN) ? (~bus.alu_a & bus.alu_b) :
                     (bus.alu_mode == ALU_NOT)  ? ~bus.alu_a : 64'd0;

  // Word-level reference for one ALU step.
  function automatic logic [63:0] ref_step(input logic [63:0] acc, input logic [63:0] b,
                                           input logic [1:0] m);
    logic [63:0] r;
    case (m)
      2'd0:    r = acc ^ b;
      2'd1:    r = ~acc & b;
      2'd2:    r = ~acc;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one burst of n words from w_data/w_mode/w_gap; hold out_ready low for
  // 'hold' cycles in DONE. poke_start pulses start in RUN gaps (must be ignored).
  task automatic run_burst(input logic [63:0] init, input logic [7:0] n,
                           input int hold, input bit poke_start,
                           output logic [63:0] result);
    logic [63:0] exp_acc;
    int          exp_rem;
    exp_acc = init;
    exp_rem = int'(n);
    start = 1'b1; init_val = init; len = n;
    step();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("acc_seed", bus.out_data, exp_acc);
    chk("rem_seed", 64'(remaining), 64'(exp_rem));
    for (int i = 0; i < int'(n); i++) begin
      for (int g = 0; g < w_gap[i]; g++) begin
        bus.in_valid = 1'b0;
        if (poke_start) begin
          start = 1'b1; init_val = ~init; len = 8'd9;
        end
        step();
        start = 1'b0;
        chk("gap_rem", 64'(remaining), 64'(exp_rem));
        chk("gap_acc", bus.out_data, exp_acc);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = w_data[i];
      bus.in_mode  = alu_mode_t'(w_mode[i]);
      #1;
      chk("in_ready_run", 64'(bus.in_ready), 64'd1);
      chk("alu_a_pass", bus.alu_a, exp_acc);
      chk("alu_b_pass", bus.alu_b, w_data[i]);
      step();
      exp_acc = ref_step(exp_acc, w_data[i], w_mode[i]);
      exp_rem--;
      chk("rem_step", 64'(remaining), 64'(exp_rem));
      chk("acc_step", bus.out_data, exp_acc);
    end
    bus.in_valid = 1'b0;
    chk("out_valid_done", 64'(bus.out_valid), 64'd1);
    chk("in_ready_done", 64'(bus.in_ready), 64'd0);
    chk("out_data_done", bus.out_data, exp_acc);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_data", bus.out_data, exp_acc);
    end
    // start coinciding with the DONE handshake must be ignored.
    bus.out_ready = 1'b1;
    start = 1'b1; init_val = ~exp_acc; len = 8'd1;
    step();
    bus.out_ready = 1'b0;
    start = 1'b0;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_acc_kept", bus.out_data, exp_acc);
    chk("idle_rem", 64'(remaining), 64'd0);
    result = exp_acc;
  endtask

  initial begin
    logic [63:0] res;
    logic [7:0]  n;
    bus.in_valid  = 1'b0;
    bus.in_data   = 64'd0;
    bus.in_mode   = ALU_XOR;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w_data[i] = 64'd0; w_mode[i] = 2'd0; w_gap[i] = 0;
    end

    // Reset state.
    step(); step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_rem", 64'(remaining), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_alu_a", bus.alu_a, 64'd0);
    rst = 1'b0;
    step();

    // 1: back-to-back XOR then ANDN.
    w_data[0] = 64'h00FF; w_mode[0] = 2'd0; w_gap[0] = 0;
    w_data[1] = 64'h0FF0; w_mode[1] = 2'd1; w_gap[1] = 0;
    run_burst(64'd0, 8'd2, 0, 1'b0, res);
    chk("t1_result", res, 64'h0F00);

    // 2: NOT of seed, then ZERO.
    w_data[0] = 64'h5555; w_mode[0] = 2'd2;
    run_burst(64'h1234, 8'd1, 0, 1'b0, res);
    chk("t2_not", res, 64'hFFFF_FFFF_FFFF_EDCB);
    w_data[0] = 64'hDEAD; w_mode[0] = 2'd3;
    run_burst(64'h1234, 8'd1, 0, 1'b0, res);
    chk("t2_zero", res, 64'd0);

    // 3: empty burst presents the seed.
    run_burst(64'hA5, 8'd0, 0, 1'b0, res);
    chk("t3_len0", res, 64'hA5);

    // 4 + 5: gapped XOR burst, result held 3 cycles, start poked in gaps.
    w_data[0] = 64'd1; w_mode[0] = 2'd0; w_gap[0] = 2;
    w_data[1] = 64'd2; w_mode[1] = 2'd0; w_gap[1] = 2;
    w_data[2] = 64'd4; w_mode[2] = 2'd0; w_gap[2] = 2;
    run_burst(64'd0, 8'd3, 3, 1'b1, res);
    chk("t5_xor7", res, 64'd7);

    // 6: reset mid-RUN with remaining=2.
    start = 1'b1; init_val = 64'hCAFE; len = 8'd4;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 64'h3; bus.in_mode = ALU_XOR;
    step(); step();
    bus.in_valid = 1'b0;
    start = 1'b1; init_val = 64'h1; len = 8'd7;
    step();
    start = 1'b0;
    chk("t6_start_ignored", 64'(remaining), 64'd2);
    chk("t6_acc_before_rst", bus.out_data, 64'hCAFE);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_acc", bus.out_data, 64'd0);
    chk("t6_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t6_rem", 64'(remaining), 64'd0);
    step();

    // Randomized bursts.
    for (int b = 0; b < 25; b++) begin
      logic [63:0] seed;
      logic [63:0] exp;
      n = 8'($urandom_range(0, 7));
      seed = {$urandom(), $urandom()};
      exp = seed;
      for (int i = 0; i < int'(n); i++) begin
        w_data[i] = {$urandom(), $urandom()};
        w_mode[i] = 2'($urandom_range(0, 3));
        w_gap[i]  = int'($urandom_range(0, 2));
        exp = ref_step(exp, w_data[i], w_mode[i]);
      end
      run_burst(seed, n, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), res);
      chk("rand_result", res, exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu_acc_sequencer
